// File: rtl/iob2axi_wr_sched_pkg.sv
// Shared AXI write-path definitions: burst length width, 4 KB page constants
// and the scheduler state encoding.
package iob2axi_wr_sched_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int BOUNDARY_4K = 4096;
    localparam int PAGE_W      = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/iob2axi_wr_sched_burst_len.sv
// Combinational burst sizing: the smallest of beats remaining, MAX_BEATS and
// beats left before the next 4 KB page boundary.
module iob2axi_burst_len
    import iob2axi_wr_sched_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BEATS = 256,
    parameter int BEAT_W    = 9
) (
    input  logic [PAGE_W-1:0] cur_addr,
    input  logic [CNT_W-1:0]  remaining,
    output logic [BEAT_W-1:0] beats
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int CW      = (CNT_W > PAGE_W + 2) ? CNT_W : PAGE_W + 2;

    logic [PAGE_W:0] to_bound_bytes;
    logic [CW-1:0]   to_bound;
    logic [CW-1:0]   rem_w;
    logic [CW-1:0]   lim;

    always_comb begin
        // Page offset 0 yields a full 4096-byte page, hence the extra bit.
        to_bound_bytes = (PAGE_W + 1)'(BOUNDARY_4K) - {1'b0, cur_addr};
        to_bound       = CW'(to_bound_bytes >> BYTE_SH);
        rem_w          = CW'(remaining);
        lim            = (rem_w < to_bound) ? rem_w : to_bound;
        if (lim > CW'(MAX_BEATS)) begin
            lim = CW'(MAX_BEATS);
        end
        beats = BEAT_W'(lim);
    end

endmodule

// File: rtl/iob2axi_wr_sched.sv
// Splits a linear write of total_len beats into AXI-legal bursts (<= MAX_BEATS,
// never crossing 4 KB) and streams upstream data to the write engine.
module iob2axi_wr_sched
    import iob2axi_wr_sched_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [CNT_W-1:0]     total_len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_wdata,
    input  logic [DATA_W/8-1:0]  s_wstrb,
    output logic                 s_ready,
    output logic [AXI_LEN_W-1:0] e_length,
    input  logic                 e_ready,
    input  logic                 e_error,
    output logic                 e_valid,
    output logic [ADDR_W-1:0]    e_addr,
    output logic [DATA_W-1:0]    e_wdata,
    output logic [DATA_W/8-1:0]  e_wstrb,
    input  logic                 e_s_ready
);

    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int BEAT_W  = $clog2(MAX_BEATS) + 1;

    state_t               state_q,     state_d;
    logic [ADDR_W-1:0]    cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [BEAT_W-1:0]    beats_q,     beats_d;
    logic [BEAT_W-1:0]    beat_cnt_q,  beat_cnt_d;
    logic [AXI_LEN_W-1:0] e_length_q,  e_length_d;
    logic                 done_q,      done_d;
    logic                 error_q,     error_d;

    logic [BEAT_W-1:0]    beats_calc;
    logic                 in_data;
    logic                 fire;

    iob2axi_burst_len #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_BEATS (MAX_BEATS),
        .BEAT_W    (BEAT_W)
    ) u_burst_len (
        .cur_addr  (cur_addr_q[PAGE_W-1:0]),
        .remaining (remaining_q),
        .beats     (beats_calc)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        e_length_d  = e_length_q;
        done_d      = 1'b0;
        error_d     = error_q;

        in_data = (state_q == DATA) && (beat_cnt_q < beats_q);
        e_valid = in_data && s_valid;
        s_ready = in_data && e_s_ready;
        e_wdata = in_data ? s_wdata : '0;
        e_wstrb = in_data ? s_wstrb : '0;
        fire    = e_valid && e_s_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = addr & ~ADDR_W'(BYTES - 1);
                    remaining_d = total_len;
                    error_d     = 1'b0;
                    if (total_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (e_ready) begin
                    beats_d    = beats_calc;
                    e_length_d = AXI_LEN_W'(beats_calc - 1'b1);
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_d == beats_q) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (e_ready) begin
                    error_d     = error_q | e_error;
                    cur_addr_d  = cur_addr_q + (ADDR_W'(beats_q) << BYTE_SH);
                    remaining_d = remaining_q - CNT_W'(beats_q);
                    if (remaining_d == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset clears every flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            e_length_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            e_length_q  <= e_length_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign e_length = e_length_q;
    assign e_addr   = cur_addr_q;

endmodule

// File: tb/tb_iob2axi_wr_sched.sv
// Randomized bench: a page/burst-splitting reference model predicts every burst
// address, length, data word and the final error flag.
module tb_iob2axi_wr_sched;
    import iob2axi_wr_sched_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;
    localparam int MAX_BEATS = 256;
    localparam int BYTES     = DATA_W / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    addr;
    logic [CNT_W-1:0]     total_len;
    logic                 busy, done, error;
    logic                 s_valid;
    logic [DATA_W-1:0]    s_wdata;
    logic [BYTES-1:0]     s_wstrb;
    logic                 s_ready;
    logic [AXI_LEN_W-1:0] e_length;
    logic                 e_ready, e_error, e_valid;
    logic [ADDR_W-1:0]    e_addr;
    logic [DATA_W-1:0]    e_wdata;
    logic [BYTES-1:0]     e_wstrb;
    logic                 e_s_ready;

    int n_checks = 0;
    int n_pass   = 0;

    iob2axi_wr_sched #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .total_len(total_len),
        .busy(busy), .done(done), .error(error),
        .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .e_length(e_length), .e_ready(e_ready), .e_error(e_error),
        .e_valid(e_valid), .e_addr(e_addr), .e_wdata(e_wdata), .e_wstrb(e_wstrb),
        .e_s_ready(e_s_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        s_valid   = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        e_ready   = 1'b0;
        e_error   = 1'b0;
        e_s_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_busy"},     busy,     0);
        check({where, "_done"},     done,     0);
        check({where, "_error"},    error,    0);
        check({where, "_e_valid"},  e_valid,  0);
        check({where, "_s_ready"},  s_ready,  0);
        check({where, "_e_length"}, e_length, 0);
        check({where, "_e_addr"},   e_addr,   0);
    endtask

    // err_idx: burst whose response carries e_error (-1 none).
    // rst_burst: burst during whose data phase rst is pulsed (-1 none).
    task automatic run_xfer(input logic [31:0] a, input int len, input int err_idx,
                            input bit rnd, input int rst_burst);
        logic [31:0] exp_addr[$];
        int          exp_beats[$];
        logic [31:0] words[$];
        logic [3:0]  strbs[$];
        logic [31:0] am;
        int          rem, page_left, b;
        int          burst_i  = 0;
        int          beat_i   = 0;
        int          gbeat    = 0;
        bit          in_resp  = 0;
        bit          resp_hs;
        bit          finished = 0;
        bit          exp_err;

        am  = a & 32'hFFFF_FFFC;
        rem = len;
        while (rem > 0) begin
            page_left = (4096 - int'(am % 4096)) / BYTES;
            b = rem;
            if (b > MAX_BEATS) b = MAX_BEATS;
            if (b > page_left) b = page_left;
            exp_addr.push_back(am);
            exp_beats.push_back(b);
            am  = am + 32'(b * BYTES);
            rem = rem - b;
        end
        exp_err = (err_idx >= 0) && (err_idx < exp_beats.size());
        for (int i = 0; i < len; i++) begin
            words.push_back($urandom);
            strbs.push_back(4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        start     = 1'b1;
        addr      = a;
        total_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        check("error_clear_on_start", error, 0);
        check("busy_after_start", busy, len != 0);
        check("done_after_start", done, len == 0);

        if (len == 0) begin
            for (int c = 0; c < 5; c++) begin
                s_valid   = 1'($urandom_range(0, 1));
                e_s_ready = 1'($urandom_range(0, 1));
                e_ready   = 1'b1;
                @(negedge clk);
                check("zero_len_done_low", done, 0);
                check("zero_len_e_valid", e_valid, 0);
                check("zero_len_s_ready", s_ready, 0);
            end
            idle_inputs();
            return;
        end

        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (rst_burst >= 0 && burst_i == rst_burst && beat_i == 2 && !in_resp) begin
                if (err_idx >= 0 && err_idx < burst_i) check("error_before_rst", error, 1);
                rst = 1'b1;
                idle_inputs();
                #1;
                check_reset_outputs("mid_rst");
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_reset_outputs("post_rst");
                return;
            end
            if (done) begin
                finished = 1;
                break;
            end
            s_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            e_s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            e_ready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_wdata   = (gbeat < len) ? words[gbeat] : $urandom;
            s_wstrb   = (gbeat < len) ? strbs[gbeat] : 4'($urandom_range(0, 15));
            e_error   = in_resp && (burst_i == err_idx);
            // Spurious starts while busy must not disturb the transfer.
            start     = rnd && ($urandom_range(0, 7) == 0);
            if (start) begin
                addr      = $urandom;
                total_len = 16'($urandom);
            end
            resp_hs = in_resp && e_ready;
            #1;
            if (in_resp) begin
                check("e_valid_low_in_resp", e_valid, 0);
                check("s_ready_low_in_resp", s_ready, 0);
            end
            if (resp_hs) begin
                in_resp = 0;
                burst_i++;
                beat_i  = 0;
            end else if (e_valid && e_s_ready) begin
                if (burst_i >= exp_beats.size()) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("burst_addr", e_addr, exp_addr[burst_i]);
                    check("burst_len", e_length, exp_beats[burst_i] - 1);
                    check("wdata", e_wdata, words[gbeat]);
                    check("wstrb", e_wstrb, strbs[gbeat]);
                    check("s_ready_on_beat", s_ready, 1);
                    gbeat++;
                    beat_i++;
                    if (beat_i == exp_beats[burst_i]) in_resp = 1;
                end
            end
            @(negedge clk);
        end

        if (!finished) check("timeout_waiting_done", 0, 1);
        check("bursts_completed", burst_i, exp_beats.size());
        check("beats_forwarded", gbeat, len);
        check("error_at_done", error, exp_err);
        check("busy_at_done", busy, 0);
        idle_inputs();
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("error_sticky", error, exp_err);
    endtask

    initial begin
        rst       = 1'b1;
        addr      = '0;
        total_len = '0;
        idle_inputs();
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(32'h0000_0000, 600, -1, 0, -1);
        run_xfer(32'h0000_0FF0, 10,  -1, 1, -1);
        run_xfer(32'h0000_1234, 0,   -1, 1, -1);
        run_xfer(32'h0000_0000, 600,  1, 1, -1);
        run_xfer(32'h0000_4000, 20,  -1, 1, -1);
        run_xfer(32'hFFFF_FF00, 100, -1, 1, -1);
        run_xfer(32'h0000_0803, 5,   -1, 1, -1);
        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom, int'($urandom_range(1, 700)),
                     int'($urandom_range(0, 3)) - 1, 1, -1);
        end
        run_xfer(32'h0000_2000, 600, 0, 1, 1);
        run_xfer(32'h0000_3000, 300, -1, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
